// File: rtl/gray_counter_n_if.sv
// Control and status bundle for gray_counter_n: count/load controls in, Gray/binary count and flags out.
interface gray_counter_n_if #(
    parameter int unsigned WIDTH = 4
);
    logic             clk_en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_gray;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic             tc;
    logic             ovf;

    modport master (
        output clk_en, up_dn, load, load_gray,
        input  gray_out, bin_out, tc, ovf
    );

    modport slave (
        input  clk_en, up_dn, load, load_gray,
        output gray_out, bin_out, tc, ovf
    );
endinterface

// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray-code counter with parallel Gray load, wrap/saturate ends,
// binary mirror output, combinational terminal count and registered end-of-range pulse.
module gray_counter_n #(
    parameter int unsigned WIDTH = 4,
    parameter bit          WRAP  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    gray_counter_n_if.slave bus
);
    localparam int unsigned      W       = WIDTH;
    localparam logic [WIDTH-1:0] MAX_CNT = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_CNT = '0;

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("gray_counter_n: WIDTH must be in the range 2..16");
        end
    endgenerate

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_ovf;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_bin_nxt;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             w_ovf_nxt;
    logic             w_at_max;
    logic             w_at_min;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_load_bin = '0;
        for (int i = 0; i < W; i++) begin
            w_load_bin[i] = ^(bus.load_gray >> i);
        end
    end

    assign w_at_max = (r_bin == MAX_CNT);
    assign w_at_min = (r_bin == MIN_CNT);

    // Next count: load beats count enable; end-of-range steps either wrap or hold, always flagging ovf.
    always_comb begin
        w_bin_nxt = r_bin;
        w_ovf_nxt = 1'b0;
        if (bus.load) begin
            w_bin_nxt = w_load_bin;
        end else if (bus.clk_en) begin
            if (bus.up_dn) begin
                if (w_at_max) begin
                    w_ovf_nxt = 1'b1;
                    w_bin_nxt = WRAP ? MIN_CNT : r_bin;
                end else begin
                    w_bin_nxt = r_bin + WIDTH'(1);
                end
            end else begin
                if (w_at_min) begin
                    w_ovf_nxt = 1'b1;
                    w_bin_nxt = WRAP ? MAX_CNT : r_bin;
                end else begin
                    w_bin_nxt = r_bin - WIDTH'(1);
                end
            end
        end
    end

    assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

    // Binary and Gray registers share one edge so the two outputs never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    assign bus.bin_out  = r_bin;
    assign bus.gray_out = r_gray;
    assign bus.ovf      = r_ovf;
    assign bus.tc       = (bus.up_dn & w_at_max) | (~bus.up_dn & w_at_min);

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed and randomised checks of gray_counter_n in wrap (4/8 bit) and saturate (4 bit) builds.
module tb_gray_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_s, rst_b;

    gray_counter_n_if #(.WIDTH(4)) a_if ();
    gray_counter_n_if #(.WIDTH(4)) s_if ();
    gray_counter_n_if #(.WIDTH(8)) b_if ();

    gray_counter_n #(.WIDTH(4), .WRAP(1'b1)) u_a (.clk(clk), .rst(rst_a), .bus(a_if));
    gray_counter_n #(.WIDTH(4), .WRAP(1'b0)) u_s (.clk(clk), .rst(rst_s), .bus(s_if));
    gray_counter_n #(.WIDTH(8), .WRAP(1'b1)) u_b (.clk(clk), .rst(rst_b), .bus(b_if));

    typedef struct {
        int          id;
        logic [15:0] gray;
        logic [15:0] bin;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_dut(input int id, output logic [15:0] g, output logic [15:0] b,
                            output logic o, output logic t);
        case (id)
            0:       begin g = 16'(a_if.gray_out); b = 16'(a_if.bin_out); o = a_if.ovf; t = a_if.tc; end
            1:       begin g = 16'(s_if.gray_out); b = 16'(s_if.bin_out); o = s_if.ovf; t = s_if.tc; end
            default: begin g = 16'(b_if.gray_out); b = 16'(b_if.bin_out); o = b_if.ovf; t = b_if.tc; end
        endcase
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        logic [15:0] og, ob;
        logic oo, ot;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        read_dut(e.id, og, ob, oo, ot);
        chk({tag, " gray"}, og, e.gray);
        chk({tag, " bin"},  ob, e.bin);
        chk({tag, " ovf"},  16'(oo), 16'(e.ovf));
    endtask

    // Drive one cycle of inputs on a DUT, queue the expected result, then compare after the edge.
    task automatic step(input int id, input logic r, input logic en, input logic up, input logic ld,
                        input logic [15:0] lg, input logic [15:0] eg, input logic [15:0] eb,
                        input logic eo, input string tag);
        exp_t e;
        case (id)
            0: begin rst_a = r; a_if.clk_en = en; a_if.up_dn = up; a_if.load = ld; a_if.load_gray = 4'(lg); end
            1: begin rst_s = r; s_if.clk_en = en; s_if.up_dn = up; s_if.load = ld; s_if.load_gray = 4'(lg); end
            default: begin rst_b = r; b_if.clk_en = en; b_if.up_dn = up; b_if.load = ld; b_if.load_gray = 8'(lg); end
        endcase
        e.id = id; e.gray = eg; e.bin = eb; e.ovf = eo;
        sb.push_back(e);
        tick();
        pop_check(tag);
        case (id)
            0:       rst_a = 1'b0;
            1:       rst_s = 1'b0;
            default: rst_b = 1'b0;
        endcase
    endtask

    task automatic chk_tc(input int id, input logic exp, input string tag);
        logic [15:0] og, ob;
        logic oo, ot;
        #1;
        read_dut(id, og, ob, oo, ot);
        chk(tag, 16'(ot), 16'(exp));
    endtask

    function automatic logic [15:0] g2b(input logic [15:0] g, input int w);
        logic acc;
        g2b = '0;
        acc = 1'b0;
        for (int i = w - 1; i >= 0; i--) begin
            acc    = acc ^ g[i];
            g2b[i] = acc;
        end
    endfunction

    function automatic void model(input int w, input bit wrap, input logic [15:0] bin,
                                  input bit r, input bit ld, input bit en, input bit up,
                                  input logic [15:0] lg, output logic [15:0] nb, output logic ov);
        int mx;
        mx = (1 << w) - 1;
        nb = bin;
        ov = 1'b0;
        if (r) nb = '0;
        else if (ld) nb = g2b(lg, w);
        else if (en) begin
            if (up) begin
                if (int'(bin) == mx) begin ov = 1'b1; nb = wrap ? 16'd0 : bin; end
                else nb = bin + 16'd1;
            end else begin
                if (bin == 16'd0) begin ov = 1'b1; nb = wrap ? 16'(mx) : bin; end
                else nb = bin - 16'd1;
            end
        end
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g1[16] = '{1, 3, 2, 6, 7, 5, 4, 'hC, 'hD, 'hF, 'hE, 'hA, 'hB, 9, 8, 0};
        int          g2[16] = '{8, 9, 'hB, 'hA, 'hE, 'hF, 'hD, 'hC, 4, 5, 7, 6, 2, 3, 1, 0};
        logic [15:0] prev, og, ob, mb, nb, lg;
        logic        oo, ot, ov, r, ld, en, up;

        rst_a = 1'b1; rst_s = 1'b1; rst_b = 1'b1;
        a_if.clk_en = 1'b1; a_if.up_dn = 1'b1; a_if.load = 1'b1; a_if.load_gray = 4'h7;
        s_if.clk_en = 1'b0; s_if.up_dn = 1'b1; s_if.load = 1'b0; s_if.load_gray = '0;
        b_if.clk_en = 1'b0; b_if.up_dn = 1'b1; b_if.load = 1'b0; b_if.load_gray = '0;
        tick();
        tick();

        // Reset state on all three builds, with load and enable active on one of them.
        for (int id = 0; id < 3; id++) begin
            read_dut(id, og, ob, oo, ot);
            chk("reset gray", og, 16'd0);
            chk("reset bin",  ob, 16'd0);
            chk("reset ovf",  16'(oo), 16'd0);
            chk("reset tc up", 16'(ot), 16'd0);
        end
        a_if.up_dn = 1'b0;
        chk_tc(0, 1'b1, "reset tc down");
        rst_a = 1'b0; rst_s = 1'b0; rst_b = 1'b0;
        a_if.load = 1'b0;

        // Test 1: wrap-mode up count through a full cycle.
        prev = '0;
        for (int k = 0; k < 16; k++) begin
            step(0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'(g1[k]), 16'((k + 1) % 16), k == 15, "t1 up");
            read_dut(0, og, ob, oo, ot);
            chk("t1 hamming", 16'($countones(og ^ prev)), 16'd1);
            chk("t1 tc", 16'(ot), 16'(g1[k] == 8));
            prev = og;
        end

        // Test 2: direction flip from 0, down count wraps to all-ones first.
        a_if.clk_en = 1'b0;
        a_if.up_dn  = 1'b0;
        chk_tc(0, 1'b1, "t2 tc at zero");
        for (int k = 0; k < 16; k++) begin
            step(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'(g2[k]), 16'(15 - k), k == 0, "t2 down");
            read_dut(0, og, ob, oo, ot);
            chk("t2 hamming", 16'($countones(og ^ prev)), 16'd1);
            prev = og;
        end

        // Test 3: load with enable low, then count up from the loaded value.
        step(0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hC, 16'hC, 16'd8,  1'b0, "t3 load");
        step(0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'hD, 16'd9,  1'b0, "t3 up1");
        step(0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'hF, 16'd10, 1'b0, "t3 up2");
        step(0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'hE, 16'd11, 1'b0, "t3 up3");

        // Test 4: saturate mode holds at the ends and pulses ovf on every blocked step.
        step(1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h9, 16'h9, 16'd14, 1'b0, "t4 load");
        step(1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h8, 16'd15, 1'b0, "t4 to max");
        step(1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h8, 16'd15, 1'b1, "t4 hold1");
        step(1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h8, 16'd15, 1'b1, "t4 hold2");
        step(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h9, 16'd14, 1'b0, "t4 down1");
        step(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'hB, 16'd13, 1'b0, "t4 down2");
        step(1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'd0,  1'b0, "t4 load0");
        chk_tc(1, 1'b1, "t4 tc at zero");
        step(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'd0,  1'b1, "t4 floor1");
        step(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'd0,  1'b1, "t4 floor2");
        step(1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'd0,  1'b0, "t4 idle");

        // Test 5: enable gating, then reset overriding a load and an end-of-range step.
        step(0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 16'd0,  1'b0, "t5 load0");
        step(0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h1, 16'd1,  1'b0, "t5 en1");
        step(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h1, 16'd1,  1'b0, "t5 en0a");
        step(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h1, 16'd1,  1'b0, "t5 en0b");
        step(0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h3, 16'd2,  1'b0, "t5 en1b");
        step(0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hF, 16'hF, 16'd10, 1'b0, "t5 loadF");
        step(0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5, 16'h0, 16'd0,  1'b0, "t5 rst+load");
        chk_tc(0, 1'b0, "t5 tc up");
        a_if.up_dn = 1'b0;
        chk_tc(0, 1'b1, "t5 tc down");
        step(0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8, 16'h8, 16'd15, 1'b0, "t5 load max");
        step(0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'd0,  1'b0, "t5 rst at max");

        // Test 6: 8-bit wrap build against the model, full up cycle then random traffic.
        mb = '0;
        for (int k = 0; k < 256; k++) begin
            model(8, 1'b1, mb, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, nb, ov);
            step(2, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, nb ^ (nb >> 1), nb, ov, "t6 up");
            mb = nb;
        end
        chk("t6 wrapped", mb, 16'd0);
        for (int k = 0; k < 300; k++) begin
            r  = ($urandom_range(0, 99) < 3);
            ld = ($urandom_range(0, 99) < 10);
            en = ($urandom_range(0, 99) < 80);
            up = 1'($urandom_range(0, 1));
            lg = 16'($urandom_range(0, 255));
            model(8, 1'b1, mb, r, ld, en, up, lg, nb, ov);
            step(2, r, en, up, ld, lg, nb ^ (nb >> 1), nb, ov, "t6 rand");
            mb = nb;
            read_dut(2, og, ob, oo, ot);
            chk("t6 tc", 16'(ot), 16'(up ? (mb == 16'd255) : (mb == 16'd0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
